// File: rtl/scrambler_pkg.sv
// Shared types, LFSR constants and LFSR helper functions for the scrambler_tx slice.
// Feedback polynomial: fb = q[8] ^ q[2] ^ q[0], shift right with fb entering at the MSB.
package scrambler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int LFSR_W = 10;
  localparam int TAP_A  = 8;
  localparam int TAP_B  = 2;
  localparam int TAP_C  = 0;

  localparam logic [LFSR_W-1:0] SEED_DEFAULT      = 10'b0010010110;
  localparam int                SYNC_W_DEFAULT    = 16;
  localparam logic [15:0]       SYNC_WORD_DEFAULT = 16'hF0F0;
  localparam int                FRAME_LEN_DEFAULT = 64;

  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] q);
    return q[TAP_A] ^ q[TAP_B] ^ q[TAP_C];
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {lfsr_fb(q), q[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/scrambler_tx_lfsr.sv
// Keystream LFSR: reloads SEED on load, steps once per advance, holds otherwise.
// fb is the keystream bit for the current state (taken before the shift).
module scr_lfsr
  import scrambler_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  output logic [LFSR_W-1:0] q,
  output logic              fb
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (load) begin
      q <= SEED;
    end else if (advance) begin
      q <= lfsr_next(q);
    end
  end

  assign fb = lfsr_fb(q);

endmodule

// File: rtl/scrambler_tx.sv
// Framing additive scrambler: unscrambled SYNC word, then FRAME_LEN scrambled payload bits.
// Optional macro SCRAMBLER_BYPASS_EN adds a bypass input captured at frame start.
module scrambler_tx
  import scrambler_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED      = SEED_DEFAULT,
  parameter int                SYNC_W    = SYNC_W_DEFAULT,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int                FRAME_LEN = FRAME_LEN_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
`ifdef SCRAMBLER_BYPASS_EN
  input  logic   bypass,
`endif
  input  logic   in_valid,
  input  logic   in_bit,
  output logic   in_ready,
  output logic   out_valid,
  output logic   out_bit,
  input  logic   out_ready,
  output logic   busy,
  output logic   frame_done,
  output state_t state_dbg
);

  localparam int SCW = (SYNC_W > 1) ? $clog2(SYNC_W) : 1;
  localparam int DCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_W - 1);
  localparam logic [DCW-1:0] DATA_LAST = DCW'(FRAME_LEN - 1);

  // Handshake: a bit moves on either side only in a cycle where valid && ready.
  // The single output register is free when empty or being drained this cycle.

  state_t             state, state_n;
  logic [SCW-1:0]     sync_cnt, sync_cnt_n;
  logic [DCW-1:0]     data_cnt, data_cnt_n;
  logic               slot_free;
  logic               load_slot;
  logic               slot_bit;
  logic               lfsr_load;
  logic               lfsr_adv;
  logic               fb;
  logic [LFSR_W-1:0]  lfsr_q;
  logic               ready_c;
  logic               done_c;
  logic               scramble_en;

`ifdef SCRAMBLER_BYPASS_EN
  logic bypass_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bypass_q <= 1'b0;
    end else if (state == IDLE && start) begin
      bypass_q <= bypass;
    end
  end

  assign scramble_en = !bypass_q;
`else
  assign scramble_en = 1'b1;
`endif

  scr_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .q       (lfsr_q),
    .fb      (fb)
  );

  assign slot_free = !out_valid || out_ready;

  always_comb begin
    state_n    = state;
    sync_cnt_n = sync_cnt;
    data_cnt_n = data_cnt;
    load_slot  = 1'b0;
    slot_bit   = 1'b0;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;
    ready_c    = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = SYNC;
          sync_cnt_n = '0;
          lfsr_load  = 1'b1;
        end
      end
      SYNC: begin
        if (slot_free) begin
          load_slot = 1'b1;
          slot_bit  = SYNC_WORD[SYNC_LAST - sync_cnt];
          if (sync_cnt == SYNC_LAST) begin
            state_n    = DATA;
            data_cnt_n = '0;
          end else begin
            sync_cnt_n = sync_cnt + SCW'(1);
          end
        end
      end
      DATA: begin
        ready_c = slot_free;
        if (in_valid && slot_free) begin
          load_slot = 1'b1;
          slot_bit  = in_bit ^ (fb & scramble_en);
          lfsr_adv  = 1'b1;
          if (data_cnt == DATA_LAST) begin
            done_c     = 1'b1;
            state_n    = IDLE;
            data_cnt_n = '0;
          end else begin
            data_cnt_n = data_cnt + DCW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sync_cnt  <= '0;
      data_cnt  <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
    end else begin
      state    <= state_n;
      sync_cnt <= sync_cnt_n;
      data_cnt <= data_cnt_n;
      if (load_slot) begin
        out_valid <= 1'b1;
        out_bit   <= slot_bit;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign in_ready   = ready_c;
  assign frame_done = done_c;
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

endmodule
